// File: rtl/pll_reconfig_pkg.sv
// pll_reconfig_pkg: register map and preset record layout for the Cyclone V pll_reconfig management port
package pll_reconfig_pkg;
  localparam logic [5:0] REG_MODE = 6'h00;
  localparam logic [5:0] REG_START = 6'h02;
  localparam logic [5:0] REG_N = 6'h03;
  localparam logic [5:0] REG_M = 6'h04;
  localparam logic [5:0] REG_C = 6'h05;
  localparam logic [5:0] REG_K = 6'h07;
  localparam int DIV_W = 18;
  localparam int DIV_ODD = 17;
  localparam int DIV_BYP = 16;
  localparam int DIV_HI = 8;
  localparam int DIV_LO = 0;
  localparam int K_W = 32;
  localparam int N_LSB = 0;
  localparam int M_LSB = 18;
  localparam int K_LSB = 36;
  localparam int C_LSB = 68;
  function automatic int rec_w(input int num_clk);
    return 68 + 18 * num_clk;
  endfunction
endpackage

// File: rtl/pll_video_reconfig_ctrl_sync2.sv
// sync2: two-flop synchroniser for a single asynchronous level
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/pll_video_reconfig_ctrl.sv
// pll_video_reconfig_ctrl: writes a divider preset to pll_reconfig over Avalon-MM and waits for relock
module pll_video_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_PRESETS = 4,
  parameter int NUM_CLK = 1,
  parameter int SETTLE_CYC = 64,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int DEFAULT_PRESET = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [$clog2(NUM_PRESETS)-1:0]            cfg_sel,
  input  logic                                      cfg_req,
  input  logic [NUM_PRESETS*(68+18*NUM_CLK)-1:0]    preset_tbl,
  output logic [5:0]                                mgmt_address,
  output logic [31:0]                               mgmt_writedata,
  output logic                                      mgmt_write,
  input  logic                                      mgmt_waitrequest,
  input  logic                                      pll_locked,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      error,
  output logic [$clog2(NUM_PRESETS)-1:0]            cur_preset
);
  localparam int SW = $clog2(NUM_PRESETS);
  localparam int RW = rec_w(NUM_CLK);
  localparam int CW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [4:0] LAST = 5'(NUM_CLK + 4);
  localparam logic [1:0] IDLE = 2'd0, WR = 2'd1, LOCK = 2'd2;
  logic [1:0] state;
  logic [4:0] step, ci;
  logic [RW-1:0] hold;
  logic [SW-1:0] sel, pend_sel, req_sel;
  logic [CW-1:0] cnt;
  logic valid, pending, locked_s, req_ok, req_go, same;
  logic [5:0] wr_addr;
  logic [31:0] wr_data;
  logic [DIV_W-1:0] c_fld;
  sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(pll_locked), .q(locked_s));
  assign req_ok = cfg_req && (int'(cfg_sel) < NUM_PRESETS);
  always_comb begin
    ci = step - 5'd4;
    c_fld = hold[C_LSB + DIV_W * int'(ci) +: DIV_W];
    req_go = req_ok || pending;
    req_sel = req_ok ? cfg_sel : pend_sel;
    same = valid && req_sel == cur_preset;
    wr_addr = step == 5'd0 ? REG_MODE : step == 5'd1 ? REG_N : step == 5'd2 ? REG_M :
              step == 5'd3 ? REG_K : step == LAST ? REG_START : REG_C;
    wr_data = step == 5'd0 ? 32'd0 :
              step == 5'd1 ? {14'b0, hold[N_LSB +: DIV_W]} :
              step == 5'd2 ? {14'b0, hold[M_LSB +: DIV_W]} :
              step == 5'd3 ? hold[K_LSB +: K_W] :
              step == LAST ? 32'd1 : {9'b0, ci, c_fld};
  end
  // Clearing valid on entry to WR forces a full rewrite if this sequence never completes.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      step <= '0;
      hold <= '0;
      sel <= '0;
      pend_sel <= '0;
      pending <= 1'b0;
      valid <= 1'b0;
      cnt <= '0;
      mgmt_address <= '0;
      mgmt_writedata <= '0;
      mgmt_write <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      cur_preset <= SW'(DEFAULT_PRESET);
    end else begin
      done <= 1'b0;
      if (state != IDLE && req_ok) begin
        pending <= 1'b1;
        pend_sel <= cfg_sel;
      end
      if (state == IDLE) begin
        if (req_go) begin
          pending <= 1'b0;
          if (same) done <= 1'b1;
          else begin
            busy <= 1'b1;
            error <= 1'b0;
            valid <= 1'b0;
            sel <= req_sel;
            hold <= preset_tbl[int'(req_sel) * RW +: RW];
            step <= '0;
            state <= WR;
          end
        end
      end else if (state == WR) begin
        if (!mgmt_write) begin
          mgmt_write <= 1'b1;
          mgmt_address <= wr_addr;
          mgmt_writedata <= wr_data;
        end else if (!mgmt_waitrequest) begin
          mgmt_write <= 1'b0;
          step <= step + 5'd1;
          if (step == LAST) begin
            state <= LOCK;
            cnt <= '0;
          end
        end
      end else begin
        if (locked_s && cnt >= CW'(SETTLE_CYC)) begin
          done <= 1'b1;
          cur_preset <= sel;
          valid <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          error <= 1'b1;
          valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_pll_video_reconfig_ctrl.sv
// tb_pll_video_reconfig_ctrl: directed bench with reconfig-core stall model, write logger and lock model
module tb_pll_video_reconfig_ctrl;
  localparam int NP = 4, NC = 2, SETTLE = 64, LT = 400, RW = 68 + 18 * NC;
  logic clk = 0, rst_n = 0, cfg_req = 0, pll_locked = 0, mgmt_waitrequest = 0;
  logic [1:0] cfg_sel = 0;
  logic [NP*RW-1:0] preset_tbl;
  logic [5:0] mgmt_address;
  logic [31:0] mgmt_writedata;
  logic mgmt_write, busy, done, error;
  logic [1:0] cur_preset;
  pll_video_reconfig_ctrl #(.NUM_PRESETS(NP), .NUM_CLK(NC), .SETTLE_CYC(SETTLE),
                            .LOCK_TIMEOUT(LT), .DEFAULT_PRESET(0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_sel(cfg_sel), .cfg_req(cfg_req), .preset_tbl(preset_tbl),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata), .mgmt_write(mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked), .busy(busy), .done(done),
    .error(error), .cur_preset(cur_preset));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [17:0] pn[4] = '{18'h00101, 18'h10000, 18'h00202, 18'h00303};
  logic [17:0] pm[4] = '{18'h00202, 18'h20605, 18'h00F0F, 18'h01010};
  logic [31:0] pk[4] = '{32'h0, 32'h599E7A7D, 32'h12345678, 32'hCAFEF00D};
  logic [17:0] pc0[4] = '{18'h00303, 18'h00A0A, 18'h00505, 18'h00707};
  logic [17:0] pc1[4] = '{18'h00404, 18'h20B0A, 18'h00606, 18'h10808};
  logic [37:0] t1_exp[7] = '{{6'h00, 32'h0}, {6'h03, 32'h00010000}, {6'h04, 32'h00020605},
                             {6'h07, 32'h599E7A7D}, {6'h05, 32'h00000A0A}, {6'h05, 32'h00060B0A},
                             {6'h02, 32'h1}};
  int lock_mode = 0, lock_dly = 100, force_stall = 0, wcnt = 0, nlog = 0, start_cyc = 0;
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0, err_cyc = 0, unstable = 0, gap_err = 0;
  bit in_wr = 0, prev_cmp = 0, started = 0, prev_err = 0;
  logic [37:0] log_w[256];
  logic [37:0] cap;
  initial forever begin
    @(negedge clk);
    if (mgmt_write) begin
      if (prev_cmp) gap_err++;
      if (!in_wr) begin
        in_wr = 1;
        wcnt = force_stall > 0 ? force_stall : int'($urandom_range(0, 3));
        cap = {mgmt_address, mgmt_writedata};
      end else begin
        if (wcnt > 0) wcnt--;
        if ({mgmt_address, mgmt_writedata} != cap) unstable++;
      end
      mgmt_waitrequest = wcnt != 0;
      prev_cmp = !mgmt_waitrequest;
      if (prev_cmp) begin
        if (nlog < 256) log_w[nlog] = {mgmt_address, mgmt_writedata};
        nlog++;
        in_wr = 0;
        if (mgmt_address == 6'h02) begin start_cyc = cyc + 1; started = 1; end
        if (mgmt_address == 6'h00) started = 0;
      end
    end else begin
      in_wr = 0;
      prev_cmp = 0;
      mgmt_waitrequest = 0;
    end
    pll_locked = lock_mode == 2 || (lock_mode == 1 && started && cyc >= start_cyc + lock_dly);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (error && !prev_err) err_cyc = cyc;
    prev_err = error;
  end
  int n_chk = 0, n_fail = 0, rq_cyc = 0, l0, d0, b0, u0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic req(input logic [1:0] s);
    step();
    cfg_sel = s;
    cfg_req = 1;
    rq_cyc = cyc;
    step();
    cfg_req = 0;
  endtask
  task automatic wait_done(input int target, input int bound, input string tag);
    for (int i = 0; i < bound && done_cnt < target; i++) step();
    chk(tag, done_cnt, target);
  endtask
  task automatic chk_seq(input string tag, input int base, input int p);
    logic [37:0] e[7];
    e[0] = {6'h00, 32'd0};
    e[1] = {6'h03, 14'b0, pn[p]};
    e[2] = {6'h04, 14'b0, pm[p]};
    e[3] = {6'h07, pk[p]};
    e[4] = {6'h05, 9'b0, 5'd0, pc0[p]};
    e[5] = {6'h05, 9'b0, 5'd1, pc1[p]};
    e[6] = {6'h02, 32'd1};
    for (int i = 0; i < 7; i++) chk($sformatf("%s_w%0d", tag, i), (base + i < 256) ? log_w[base + i] : 'x, e[i]);
  endtask
  initial begin
    for (int i = 0; i < NP; i++) preset_tbl[i*RW +: RW] = {pc1[i], pc0[i], pk[i], pm[i], pn[i]};
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cur", cur_preset, 0);
    chk("rst_write", mgmt_write, 0);
    chk("rst_addr", mgmt_address, 0);
    chk("rst_data", mgmt_writedata, 0);
    rst_n = 1;
    step();
    // full write sequence for preset 1
    lock_mode = 1; l0 = nlog; d0 = done_cnt;
    req(1);
    wait_done(d0 + 1, 2000, "t1_done");
    repeat (5) step();
    chk("t1_nlog", nlog - l0, 7);
    for (int i = 0; i < 7; i++) chk($sformatf("t1_w%0d", i), log_w[l0 + i], t1_exp[i]);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_cur", cur_preset, 1);
    chk("t1_lock_wait", done_cyc - start_cyc >= 100, 1);
    chk("t1_busy", busy, 0);
    // same preset again: no writes
    l0 = nlog; d0 = done_cnt; b0 = busy_cnt;
    req(1);
    repeat (5) step();
    chk("t2_nlog", nlog - l0, 0);
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_lat", done_cyc - rq_cyc, 1);
    chk("t2_busy", busy_cnt - b0, 0);
    // lock timeout then recovery
    lock_mode = 0;
    req(2);
    for (int i = 0; i < 2000 && !error; i++) step();
    chk("t3_err", error, 1);
    chk("t3_tmo_cyc", err_cyc - start_cyc, LT);
    chk("t3_cur", cur_preset, 1);
    chk("t3_busy", busy, 0);
    lock_mode = 1; l0 = nlog; d0 = done_cnt;
    req(1);
    chk("t3_err_clr", error, 0);
    chk("t3_busy_set", busy, 1);
    wait_done(d0 + 1, 2000, "t3_done");
    repeat (3) step();
    chk_seq("t3", l0, 1);
    chk("t3_cur2", cur_preset, 1);
    // requests while busy: latest pending wins
    d0 = done_cnt;
    req(0);
    wait_done(d0 + 1, 2000, "t4_pre");
    l0 = nlog; d0 = done_cnt;
    req(1);
    repeat (10) step();
    req(2);
    repeat (5) step();
    req(3);
    wait_done(d0 + 2, 3000, "t4_done");
    repeat (5) step();
    chk("t4_nlog", nlog - l0, 14);
    chk_seq("t4a", l0, 1);
    chk_seq("t4b", l0 + 7, 3);
    chk("t4_cur", cur_preset, 3);
    chk("t4_done_cnt", done_cnt - d0, 2);
    // settle time with locked always high, long stalls
    lock_mode = 2; force_stall = 20; u0 = unstable; l0 = nlog; d0 = done_cnt;
    req(2);
    wait_done(d0 + 1, 3000, "t5_done");
    force_stall = 0;
    chk("t5_settle", done_cyc - start_cyc >= SETTLE, 1);
    chk_seq("t5", l0, 2);
    chk("t5_stable", unstable - u0, 0);
    chk("t5_cur", cur_preset, 2);
    // reset during a C write
    lock_mode = 1; force_stall = 20;
    req(3);
    for (int i = 0; i < 500 && !(mgmt_write && mgmt_address == 6'h05); i++) step();
    chk("t6_at_c", {mgmt_write, mgmt_address}, {1'b1, 6'h05});
    rst_n = 0;
    #1;
    chk("t6_write", mgmt_write, 0);
    chk("t6_addr", mgmt_address, 0);
    chk("t6_data", mgmt_writedata, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_error", error, 0);
    chk("t6_cur", cur_preset, 0);
    force_stall = 0;
    repeat (3) step();
    rst_n = 1;
    step();
    l0 = nlog; d0 = done_cnt;
    req(0);
    wait_done(d0 + 1, 2000, "t6_redone");
    repeat (3) step();
    chk("t6_nlog", nlog - l0, 7);
    chk_seq("t6", l0, 0);
    chk("t6_cur2", cur_preset, 0);
    chk("gap", gap_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
